// File: rtl/z80_io_pkg.sv
// z80_io_pkg
// Shared definitions for the Z80 bus-cycle controllers.
//   io_state_t : machine-cycle phases of an I/O access (IDLE, T1, T2, TW, T3)
//   ADDR_W     : address bus width (A15..A0)
//   DATA_W     : data bus width (D7..D0)
//   io_req_t   : a latched core request {we, addr, wdata}, shared with the
//                memory-cycle controller so both capture requests the same way
package z80_io_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } io_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } io_req_t;

endpackage

// File: rtl/z80_wait_timer.sv
// z80_wait_timer
// Saturating count of WAIT_L-extended TW cycles for one bus access.
// Ports:
//   clk_i    : clock
//   rst_l_i  : asynchronous active-low reset
//   clr_i    : restart the count at zero (new access accepted)
//   inc_i    : count one more wait cycle; ignored once the count is at MAX_CNT
//   at_max_o : count has reached MAX_CNT, no further waits may be granted
// MAX_CNT must be at least 1 so the counter has a non-zero width.
module z80_wait_timer #(
  parameter int MAX_CNT = 255,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk_i,
  input  logic rst_l_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max_o = (cnt_q == CNT_W'(MAX_CNT));

  // Clear wins over increment so a fresh access always starts from zero.
  // The count saturates at MAX_CNT instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously with the rest of the bus logic.
  always_ff @(posedge clk_i or negedge rst_l_i) begin
    if (!rst_l_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/z80_io_bus_ctrl.sv
// z80_io_bus_ctrl
// Turns a single-cycle IN/OUT request from the core into a Z80 I/O machine
// cycle (T1, T2, mandatory TW, WAIT_L-extended TW, T3) on the shared bus.
// Ports:
//   clk, rst_L           : clock, asynchronous active-low reset
//   req, we              : request strobe and direction (1 = OUT), taken when ready
//   port_addr, wdata     : full I/O address and write data, taken with req
//   WAIT_L               : device wait request, looked at only during TW
//   ready                : controller idle, a request will be accepted
//   done, err            : one-cycle completion pulse, err = wait timeout
//   rdata                : data captured at the end of the last read
//   IORQ_L, RD_L, WR_L   : active-low bus strobes
//   addr_bus, data_bus   : tri-state buses, driven only during T1..T3
module z80_io_bus_ctrl
  import z80_io_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] port_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              WAIT_L,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L,
  inout  wire  [ADDR_W-1:0] addr_bus,
  inout  wire  [DATA_W-1:0] data_bus
);

  io_state_t         state_q;
  io_state_t         state_d;
  io_req_t           req_q;
  logic              err_flag_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              iorq_l_q;
  logic              rd_l_q;
  logic              wr_l_q;
  logic              addr_oe_q;
  logic              data_oe_q;

  logic              accept;
  logic              wait_inc;
  logic              wait_at_max;
  logic              timeout;
  logic              next_we;
  logic              strobe_d;
  logic              drive_d;

  assign accept   = (state_q == IDLE) && req;
  assign wait_inc = (state_q == TW) && !WAIT_L && !wait_at_max;
  assign timeout  = (state_q == TW) && !WAIT_L && wait_at_max;

  z80_wait_timer #(
    .MAX_CNT (MAX_WAIT)
  ) u_wait_timer (
    .clk_i    (clk),
    .rst_l_i  (rst_L),
    .clr_i    (accept),
    .inc_i    (wait_inc),
    .at_max_o (wait_at_max)
  );

  // Next machine-cycle phase. TW is always entered once; it repeats only
  // while the device holds WAIT_L low and the wait budget is not exhausted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = TW;
      TW:      if (!wait_inc) state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and bus enables are registered from the next phase so they line
  // up with the phase itself. On the accepting edge the latched direction is
  // not yet valid, so the live 'we' input decides the data-bus enable.
  assign next_we  = (state_q == IDLE) ? we : req_q.we;
  assign strobe_d = (state_d == T2) || (state_d == TW) || (state_d == T3);
  assign drive_d  = (state_d != IDLE);

  // Phase register, request latch, timeout flag, read capture and the
  // registered bus-facing outputs.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      req_q      <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      iorq_l_q   <= 1'b1;
      rd_l_q     <= 1'b1;
      wr_l_q     <= 1'b1;
      addr_oe_q  <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        req_q      <= '{we: we, addr: port_addr, wdata: wdata};
        err_flag_q <= 1'b0;
      end else if (timeout) begin
        err_flag_q <= 1'b1;
      end

      // Completion is reported in the cycle after T3, together with the
      // strobes returning high and the buses floating.
      done_q <= (state_q == T3);
      err_q  <= (state_q == T3) && err_flag_q;

      if ((state_q == T3) && !req_q.we) begin
        rdata_q <= data_bus;
      end

      iorq_l_q  <= !strobe_d;
      rd_l_q    <= !(strobe_d && !next_we);
      wr_l_q    <= !(strobe_d && next_we);
      addr_oe_q <= drive_d;
      data_oe_q <= drive_d && next_we;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign IORQ_L   = iorq_l_q;
  assign RD_L     = rd_l_q;
  assign WR_L     = wr_l_q;
  assign addr_bus = addr_oe_q ? req_q.addr : {ADDR_W{1'bz}};
  assign data_bus = data_oe_q ? req_q.wdata : {DATA_W{1'bz}};

endmodule

// File: doc/z80_io_bus_ctrl.md
Name: z80_io_bus_ctrl

Overview:
CPU-side I/O bus cycle controller. It sits directly upstream of the z80_ports I/O device model, between the core's execution unit and the shared Z80 bus. It converts a single-cycle core request (IN/OUT) into a Z80 I/O machine cycle (T1, T2, automatic TW, extra TW on WAIT_L, T3) on IORQ_L/RD_L/WR_L/addr_bus/data_bus. It returns read data and a completion pulse to the core.

Parameters:
MAX_WAIT, 255, maximum extra TW cycles inserted by WAIT_L before forced completion with error (width of wait counter = $clog2(MAX_WAIT+1)).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_L  input  1  asynchronous active-low reset.
req  input  1  core request; sampled only when ready=1.
we  input  1  1 = OUT (write), 0 = IN (read); sampled with req.
port_addr  input  16  full I/O address (A15..A8 = B/A register, A7..A0 = port); sampled with req.
wdata  input  8  write data; sampled with req.
WAIT_L  input  1  device wait request, active-low, sampled in TW.
ready  output  1  1 in IDLE; request accepted when req & ready.
done  output  1  one-cycle pulse after T3 completes.
rdata  output  8  data captured at end of T3 of a read; holds until next read completes.
err  output  1  valid with done; 1 = wait timeout occurred.
IORQ_L  output  1  I/O request strobe, active-low.
RD_L  output  1  read strobe, active-low.
WR_L  output  1  write strobe, active-low.
addr_bus  inout  16  driven with latched address T1..T3, else Z.
data_bus  inout  8  driven with latched wdata T1..T3 of a write only, else Z.

Behaviour:
- Reset (async, immediate): state=IDLE; IORQ_L=RD_L=WR_L=1; addr_bus, data_bus = Z; done=0, err=0, rdata=8'h00, wait_cnt=0.
- States: IDLE, T1, T2, TW, T3 (one clock each except TW).
- IDLE: ready=1. On req: latch we/port_addr/wdata; clear wait_cnt; go T1. Otherwise stay.
- T1: addr_bus driven; data_bus driven if write; all strobes high; go T2.
- T2: IORQ_L=0; RD_L=0 (read) or WR_L=0 (write); go TW.
- TW: strobes stay low. If WAIT_L=0 and wait_cnt<MAX_WAIT, increment wait_cnt and stay. If WAIT_L=0 and wait_cnt==MAX_WAIT, set err flag and go T3. Otherwise go T3. The first TW is mandatory regardless of WAIT_L.
- T3: strobes low; at the edge leaving T3, a read captures data_bus into rdata. Go IDLE. done=1 and err=flag in the following cycle.
- Strobes and buses are registered outputs derived from next state. Strobes go high and buses go Z in the same cycle done is high.
- Latency with no WAIT_L: req accepted at edge 0; T1=cycle1, T2=2, TW=3, T3=4, done high in cycle 5. Each WAIT_L-low TW sample adds one cycle.
- Back-to-back: ready=1 during the done cycle. A req there starts T1 the next cycle.
- req while not ready: ignored, with no queuing.
- Bus contention: data_bus is never driven during reads. A write drives data_bus only while the state is T1..T3.
- Reset mid-cycle: strobes deassert and buses float asynchronously. No done is produced for the aborted access.
- WAIT_L is ignored outside TW.

Decomposition:
- Shared package z80_io_pkg holds:
  - io_state_t enum (IDLE, T1, T2, TW, T3);
  - the bus-width constants ADDR_W=16 and DATA_W=8;
  - the io_req_t struct {we, addr, wdata}, reusable by the memory-cycle controller.
- One natural sub-module, z80_wait_timer: a parameterised saturating counter with clear, inc, and at_max outputs. Everything else stays in the top FSM.

Test Plan:
- Reset values: with rst_L=0, IORQ_L/RD_L/WR_L=1, addr_bus and data_bus = Z, ready=1, rdata=00.
- Read: attach z80_ports (port i resets to i); IN port_addr=16'h1242 -> IORQ_L/RD_L low in cycles 2..4, done in cycle 5, rdata=8'h42, err=0.
- Write then read: OUT port_addr=16'h0010, wdata=8'hA5 -> WR_L low cycles 2..4, data_bus=A5 cycles 1..4, done cycle 5; a following IN from 16'h0010 -> rdata=8'hA5.
- Wait states: WAIT_L held low for the first 3 TW samples on a read -> TW occupies cycles 3..6, T3 cycle 7, done cycle 8, err=0.
- Timeout: MAX_WAIT=4, WAIT_L stuck low -> TW cycles 3..7, done cycle 9 with err=1; strobes high in cycle 9.
- Reset mid-access and back-to-back:
  - Assert rst_L low during T2 -> strobes high and buses Z immediately; no done; next req completes normally.
  - A req issued in a done cycle starts T1 on the next cycle.
